// File: rtl/teclado_ascii_fifo.sv
// PS/2 set-2 scan-code decoder that translates make codes to ASCII and queues
// them in a small FIFO for a polled or interrupt-driven consumer.
module teclado_ascii_fifo #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            scan_code,
  input  logic                  DoRead,
  output logic [7:0]            ascii_code,
  output logic                  interrupt,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned            Depth    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]    CntFull  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]    CntOne   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0]  PtrOne   = DEPTH_LOG2'(1);
  localparam logic [7:0]             CodeExt  = 8'hE0;
  localparam logic [7:0]             CodeBrk  = 8'hF0;

  typedef enum logic [1:0] {StIdle, StExt, StBreak} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              mem_q [Depth];

  logic                    norm_hit, ext_hit;
  logic [7:0]              norm_char, ext_char;
  logic                    push, do_push, do_pop, empty, full;
  logic [7:0]              push_data;

  // Make-code translation tables
  always_comb begin
    norm_hit  = 1'b1;
    norm_char = 8'h00;
    case (scan_code)
      8'h45:   norm_char = 8'h30;
      8'h16:   norm_char = 8'h31;
      8'h1E:   norm_char = 8'h32;
      8'h26:   norm_char = 8'h33;
      8'h25:   norm_char = 8'h34;
      8'h2E:   norm_char = 8'h35;
      8'h36:   norm_char = 8'h36;
      8'h3D:   norm_char = 8'h37;
      8'h3E:   norm_char = 8'h38;
      8'h46:   norm_char = 8'h39;
      8'h5A:   norm_char = 8'h0D;
      8'h29:   norm_char = 8'h20;
      8'h76:   norm_char = 8'h1B;
      8'h43:   norm_char = 8'h69;
      8'h21:   norm_char = 8'h63;
      8'h2D:   norm_char = 8'h72;
      8'h2B:   norm_char = 8'h66;
      8'h33:   norm_char = 8'h68;
      default: norm_hit  = 1'b0;
    endcase
  end

  always_comb begin
    ext_hit  = 1'b1;
    ext_char = 8'h00;
    case (scan_code)
      8'h75:   ext_char = 8'h11;
      8'h72:   ext_char = 8'h12;
      8'h6B:   ext_char = 8'h13;
      8'h74:   ext_char = 8'h14;
      default: ext_hit  = 1'b0;
    endcase
  end

  // Prefix decoder; advances only on receiver strobes
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = 8'h00;
    if (rx_done_tick) begin
      case (state_q)
        StIdle: begin
          if (scan_code == CodeBrk) begin
            state_d = StBreak;
          end else if (scan_code == CodeExt) begin
            state_d = StExt;
          end else begin
            push      = norm_hit;
            push_data = norm_char;
          end
        end
        StExt: begin
          if (scan_code == CodeBrk) begin
            state_d = StBreak;
          end else begin
            state_d   = StIdle;
            push      = ext_hit;
            push_data = ext_char;
          end
        end
        StBreak: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts
  always_comb begin
    do_pop     = DoRead && !empty;
    do_push    = push && (!full || do_pop);
    overflow_d = overflow_q || (push && full && !do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d    = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the empty flag masks stale contents
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign ascii_code = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign interrupt  = !empty;
  assign overflow   = overflow_q;
  assign count      = count_q;

endmodule
